// File: rtl/avalon_cpu_bridge.sv
// Single-outstanding CPU data port to Avalon-MM bridge: byte/half/word loads and stores,
// byte-enable generation, lane steering of load data, misalignment and wait-state timeout errors.
module avalon_cpu_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Req,
    input  logic        i_We,
    input  logic [31:0] i_Addr,
    input  logic [1:0]  i_Size,
    input  logic        i_Unsigned,
    input  logic [31:0] i_WData,
    output logic        o_Done,
    output logic        o_Err,
    output logic [31:0] o_RData,
    output logic [29:0] o_AV_Addr,
    output logic [3:0]  o_AV_ByteEn,
    output logic        o_AV_Read,
    output logic        o_AV_Write,
    output logic [31:0] o_AV_WriteData,
    input  logic [31:0] i_AV_ReadData,
    input  logic        i_AV_WaitRequest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  addr_lo_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [31:0] wait_cnt_r;

    logic [3:0]  req_be_s;
    logic [31:0] req_wdata_s;
    logic        req_bad_s;

    // Move the addressed lane down to bit 0, then truncate and extend to the access size.
    function automatic logic [31:0] load_extend(
        input logic [31:0] rdata,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] sh;
        sh = rdata >> {lo, 3'b000};
        case (size)
            2'b00:   return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Decode the incoming request: byte enables, replicated store data and alignment check.
    always_comb begin
        req_be_s    = 4'b0000;
        req_wdata_s = 32'd0;
        req_bad_s   = 1'b1;
        case (i_Size)
            2'b00: begin
                req_be_s    = 4'b0001 << i_Addr[1:0];
                req_wdata_s = {4{i_WData[7:0]}};
                req_bad_s   = 1'b0;
            end
            2'b01: begin
                req_be_s    = 4'b0011 << i_Addr[1:0];
                req_wdata_s = {2{i_WData[15:0]}};
                req_bad_s   = i_Addr[0];
            end
            2'b10: begin
                req_be_s    = 4'b1111;
                req_wdata_s = i_WData;
                req_bad_s   = |i_Addr[1:0];
            end
            default: begin
                req_be_s    = 4'b0000;
                req_wdata_s = 32'd0;
                req_bad_s   = 1'b1;
            end
        endcase
    end

    // Transfer FSM; every output is a register so the slaves see glitch-free strobes.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r        <= ST_IDLE;
            addr_lo_r      <= 2'b00;
            size_r         <= 2'b00;
            uns_r          <= 1'b0;
            wait_cnt_r     <= 32'd0;
            o_Done         <= 1'b0;
            o_Err          <= 1'b0;
            o_RData        <= 32'd0;
            o_AV_Addr      <= 30'd0;
            o_AV_ByteEn    <= 4'b0000;
            o_AV_Read      <= 1'b0;
            o_AV_Write     <= 1'b0;
            o_AV_WriteData <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_Done  <= 1'b0;
                    o_Err   <= 1'b0;
                    o_RData <= 32'd0;
                    if (i_Req) begin
                        addr_lo_r <= i_Addr[1:0];
                        size_r    <= i_Size;
                        uns_r     <= i_Unsigned;
                        if (req_bad_s) begin
                            state_r <= ST_RESP;
                            o_Done  <= 1'b1;
                            o_Err   <= 1'b1;
                        end else begin
                            state_r        <= ST_BUS;
                            wait_cnt_r     <= 32'd0;
                            o_AV_Addr      <= i_Addr[31:2];
                            o_AV_ByteEn    <= req_be_s;
                            o_AV_WriteData <= req_wdata_s;
                            o_AV_Read      <= ~i_We;
                            o_AV_Write     <= i_We;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (!i_AV_WaitRequest) begin
                        state_r    <= ST_RESP;
                        o_AV_Read  <= 1'b0;
                        o_AV_Write <= 1'b0;
                        o_Done     <= 1'b1;
                        o_Err      <= 1'b0;
                        o_RData    <= o_AV_Read ? load_extend(i_AV_ReadData, addr_lo_r, size_r, uns_r)
                                                : 32'd0;
                    end else if ((TIMEOUT_CYCLES != 32'd0) &&
                                 (wait_cnt_r == TIMEOUT_CYCLES - 32'd1)) begin
                        // The slave has stalled too long: abandon the transfer and flag it.
                        state_r    <= ST_RESP;
                        o_AV_Read  <= 1'b0;
                        o_AV_Write <= 1'b0;
                        o_Done     <= 1'b1;
                        o_Err      <= 1'b1;
                        o_RData    <= 32'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    o_Done  <= 1'b0;
                    o_Err   <= 1'b0;
                    o_RData <= 32'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_cpu_bridge.sv
// Directed bench for avalon_cpu_bridge: a per-cycle expectation model driven from transfer
// descriptions, compared against the DUT on every falling clock edge, plus literal spot checks.
module tb_avalon_cpu_bridge;

    localparam int TOUT = 8;

    logic        r_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_Req = 1'b0;
    logic        i_We = 1'b0;
    logic [31:0] i_Addr = 32'd0;
    logic [1:0]  i_Size = 2'b00;
    logic        i_Unsigned = 1'b0;
    logic [31:0] i_WData = 32'd0;
    logic        o_Done;
    logic        o_Err;
    logic [31:0] o_RData;
    logic [29:0] o_AV_Addr;
    logic [3:0]  o_AV_ByteEn;
    logic        o_AV_Read;
    logic        o_AV_Write;
    logic [31:0] o_AV_WriteData;
    logic [31:0] i_AV_ReadData = 32'd0;
    logic        i_AV_WaitRequest = 1'b0;

    avalon_cpu_bridge #(.TIMEOUT_CYCLES(TOUT)) dut (
        .i_Clk            (r_Clk),
        .i_Rst_n          (i_Rst_n),
        .i_Req            (i_Req),
        .i_We             (i_We),
        .i_Addr           (i_Addr),
        .i_Size           (i_Size),
        .i_Unsigned       (i_Unsigned),
        .i_WData          (i_WData),
        .o_Done           (o_Done),
        .o_Err            (o_Err),
        .o_RData          (o_RData),
        .o_AV_Addr        (o_AV_Addr),
        .o_AV_ByteEn      (o_AV_ByteEn),
        .o_AV_Read        (o_AV_Read),
        .o_AV_Write       (o_AV_Write),
        .o_AV_WriteData   (o_AV_WriteData),
        .i_AV_ReadData    (i_AV_ReadData),
        .i_AV_WaitRequest (i_AV_WaitRequest)
    );

    always #5 r_Clk = ~r_Clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic        exp_read = 1'b0;
    logic        exp_write = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic [29:0] exp_addr = 30'd0;
    logic [3:0]  exp_be = 4'd0;
    logic [31:0] exp_wd = 32'd0;
    logic [31:0] cap_rdata = 32'd0;
    logic [3:0]  cap_be = 4'd0;
    logic [31:0] cap_wd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("av_read", {31'd0, o_AV_Read}, {31'd0, exp_read});
        chk("av_write", {31'd0, o_AV_Write}, {31'd0, exp_write});
        chk("done", {31'd0, o_Done}, {31'd0, exp_done});
        chk("err", {31'd0, o_Err}, {31'd0, exp_err});
        chk("rdata", o_RData, exp_rdata);
        chk("rw_exclusive", {31'd0, o_AV_Read & o_AV_Write}, 32'd0);
        if (exp_read || exp_write) begin
            chk("av_addr", {2'b00, o_AV_Addr}, {2'b00, exp_addr});
            chk("av_byteen", {28'd0, o_AV_ByteEn}, {28'd0, exp_be});
        end
        if (exp_write) chk("av_wdata", o_AV_WriteData, exp_wd);
        if (o_Done === 1'b1) begin
            done_cnt++;
            cap_rdata = o_RData;
        end
        if (o_AV_Read === 1'b1 || o_AV_Write === 1'b1) begin
            cap_be = o_AV_ByteEn;
            cap_wd = o_AV_WriteData;
        end
    endtask

    // One CPU transfer: nwait<0 means the slave never releases; rst_at>0 resets after that edge.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input int nwait,
                           input logic [31:0] slv_rdata, input int rst_at);
        int          nbytes;
        int          lo;
        int          be_i;
        logic        bad;
        logic        fin;
        logic [31:0] mask;
        logic [31:0] ld;
        logic [31:0] wd_rep;
        nbytes = 1 << size;
        lo     = int'(addr % 32'd4);
        bad    = (size == 2'b11) || ((addr % nbytes) != 0);
        be_i   = ((1 << nbytes) - 1) << lo;
        for (int k = 0; k < 4; k++) wd_rep[8*k +: 8] = wdata[8*(k % 4 % nbytes) +: 8];
        mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        ld   = (slv_rdata >> (8 * lo)) & mask;
        if (!uns && nbytes < 4 && ld[8*nbytes-1]) ld = ld | ~mask;

        i_We = we; i_Addr = addr; i_Size = size; i_Unsigned = uns; i_WData = wdata;
        i_AV_ReadData = slv_rdata; i_AV_WaitRequest = (nwait != 0);
        i_Req = 1'b1;
        @(posedge r_Clk); #1;
        i_Req = 1'b0;
        if (bad) begin
            exp_done = 1'b1; exp_err = 1'b1; exp_rdata = 32'd0;
            @(posedge r_Clk); #1;
            exp_done = 1'b0; exp_err = 1'b0;
        end else begin
            exp_read = !we; exp_write = we;
            exp_addr = addr[31:2]; exp_be = be_i[3:0]; exp_wd = wd_rep;
            fin = 1'b0;
            for (int k = 1; k <= TOUT + 40 && !fin; k++) begin
                @(posedge r_Clk); #1;
                if (k == rst_at) begin
                    i_Rst_n = 1'b0;
                    exp_read = 1'b0; exp_write = 1'b0;
                    exp_done = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
                    #1;
                    chk("reset_drops_read", {31'd0, o_AV_Read}, 32'd0);
                    repeat (2) @(posedge r_Clk);
                    #1;
                    i_Rst_n = 1'b1;
                    i_AV_WaitRequest = 1'b0;
                    fin = 1'b1;
                end else if ((nwait >= 0 && k == nwait + 1) || k == TOUT) begin
                    exp_read = 1'b0; exp_write = 1'b0; exp_done = 1'b1;
                    exp_err   = (k == TOUT) && !(nwait >= 0 && k == nwait + 1);
                    exp_rdata = (we || exp_err) ? 32'd0 : ld;
                    @(posedge r_Clk); #1;
                    exp_done = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
                    i_AV_WaitRequest = 1'b0;
                    fin = 1'b1;
                end else begin
                    i_AV_WaitRequest = (nwait < 0) || (k < nwait);
                end
            end
        end
    endtask

    initial begin
        int d0;
        fork
            forever begin
                @(negedge r_Clk);
                compare_cycle();
            end
        join_none
        #1;
        chk("reset_outputs", {o_Done, o_Err, o_AV_Read, o_AV_Write, o_AV_ByteEn, o_AV_Addr[23:0]}, 32'd0);
        chk("reset_rdata", o_RData, 32'd0);
        repeat (2) @(posedge r_Clk);
        #1;
        i_Rst_n = 1'b1;
        @(posedge r_Clk); #1;

        d0 = done_cnt;
        run_txn(1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h5A5A_5A5A, 5, 32'h0, 0);
        chk("word_store_done", done_cnt - d0, 32'd1);
        chk("word_store_be", {28'd0, cap_be}, 32'h0000_000F);

        run_txn(1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0, 4, 32'h5A5A_5A5A, 0);
        chk("word_load_lit", cap_rdata, 32'h5A5A_5A5A);

        run_txn(1'b0, 32'h0000_0003, 2'b00, 1'b0, 32'h0, 0, 32'h8011_2233, 0);
        chk("byte_load_signed_lit", cap_rdata, 32'hFFFF_FF80);
        chk("byte_load_be_lit", {28'd0, cap_be}, 32'h0000_0008);

        run_txn(1'b0, 32'h0000_0003, 2'b00, 1'b1, 32'h0, 0, 32'h8011_2233, 0);
        chk("byte_load_unsigned_lit", cap_rdata, 32'h0000_0080);

        run_txn(1'b1, 32'h0000_0006, 2'b01, 1'b0, 32'h0000_BEEF, 1, 32'h0, 0);
        chk("half_store_be_lit", {28'd0, cap_be}, 32'h0000_000C);
        chk("half_store_wd_lit", cap_wd, 32'hBEEF_BEEF);

        d0 = done_cnt;
        run_txn(1'b0, 32'h0000_0005, 2'b01, 1'b0, 32'h0, 0, 32'h0, 0);
        run_txn(1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'h0, 0, 32'h0, 0);
        run_txn(1'b1, 32'h0000_0002, 2'b10, 1'b0, 32'h1, 0, 32'h0, 0);
        chk("error_done_count", done_cnt - d0, 32'd3);

        d0 = done_cnt;
        run_txn(1'b0, 32'h0000_0008, 2'b10, 1'b0, 32'h0, -1, 32'hDEAD_BEEF, 0);
        chk("timeout_done", done_cnt - d0, 32'd1);
        chk("timeout_rdata_lit", cap_rdata, 32'h0);

        run_txn(1'b0, 32'h0000_0002, 2'b01, 1'b0, 32'h0, 2, 32'h8001_0000, 0);
        chk("half_load_signed_lit", cap_rdata, 32'hFFFF_8001);

        d0 = done_cnt;
        run_txn(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0, -1, 32'h0, 3);
        chk("reset_no_done", done_cnt - d0, 32'd0);

        run_txn(1'b0, 32'h0000_0004, 2'b10, 1'b1, 32'h0, 0, 32'h1234_5678, 0);
        chk("post_reset_load_lit", cap_rdata, 32'h1234_5678);

        run_txn(1'b0, 32'h0000_0000, 2'b01, 1'b1, 32'h0, 0, 32'h1234_ABCD, 0);
        chk("half_load_unsigned_lit", cap_rdata, 32'h0000_ABCD);

        run_txn(1'b1, 32'h0000_0001, 2'b00, 1'b0, 32'hFFFF_FFA5, 3, 32'h0, 0);
        chk("byte_store_be_lit", {28'd0, cap_be}, 32'h0000_0002);
        chk("byte_store_wd_lit", cap_wd, 32'hA5A5_A5A5);

        repeat (3) @(posedge r_Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
